// File: rtl/usb_data_buffer.sv
// Shared byte FIFO between the AHB register block and the USB packet engines.
// Optional sticky overflow/underflow flags under USB_DATA_BUFFER_ERR_EN.
module usb_data_buffer #(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       store_tx_data,
  input  logic [7:0] tx_data,
  input  logic       get_rx_data,
  output logic [7:0] rx_data,
  input  logic       store_rx_packet_data,
  input  logic [7:0] rx_packet_data,
  input  logic       get_tx_packet_data,
  output logic [7:0] tx_packet_data,
  output logic [6:0] buffer_occupancy
`ifdef USB_DATA_BUFFER_ERR_EN
  ,
  output logic       overflow,
  output logic       underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [6:0] FULL = 7'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [6:0]    occ;
  logic          push_req;
  logic          pop_req;
  logic          push_ok;
  logic          pop_ok;
  logic          full;
  logic          empty;
  logic [7:0]    wdata;
  logic [7:0]    head;

  // Full/empty come from the counter; pointers alias when full.
  always_comb begin
    push_req = store_tx_data | store_rx_packet_data;
    pop_req  = get_rx_data | get_tx_packet_data;
    full     = (occ == FULL);
    empty    = (occ == 7'd0);
    pop_ok   = pop_req & ~empty;
    push_ok  = push_req & (~full | pop_ok);
    wdata    = store_rx_packet_data ? rx_packet_data : tx_data;
  end

  always_ff @(posedge clk) begin
    if (!clear && push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   occ <= occ + 7'd1;
        2'b01:   occ <= occ - 7'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_comb begin
    head             = empty ? 8'h00 : mem[rd_ptr];
    rx_data          = head;
    tx_packet_data   = head;
    buffer_occupancy = occ;
  end

`ifdef USB_DATA_BUFFER_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_req && !push_ok) overflow  <= 1'b1;
      if (pop_req && empty)     underflow <= 1'b1;
    end
  end
`endif

endmodule
